gfx_line: RTL

- Bresenham line rasteriser that sits directly upstream of the framebuffer-writer stage in the gfx pipeline, in place of or alongside the test-pattern generator.
- Accepts one line command (two endpoints plus colour) through a ready/valid handshake.
- Emits one (x, y, color) pixel per advance with the same valid/inc/last contract as the pattern generator, so the existing address math (FB_WIDTH*y + x) and fb-writer staging reuse it unchanged.

---
 rtl/gfx_line_pkg.sv | 18 +
 rtl/gfx_line.sv | 139 +++++++++++++
 2 files changed

// File: rtl/gfx_line_pkg.sv
// Shared gfx definitions: line-rasteriser state encoding and helpers that
// derive coordinate field widths from the framebuffer dimensions.
package gfx_line_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;

  // Bits needed to index n pixels along one axis (at least one bit).
  function automatic int fb_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gfx_line.sv
// Bresenham line rasteriser. Takes one (x0,y0)->(x1,y1) command with a colour
// and emits one pixel per accepted inc, using the same valid/inc/last contract
// as the test-pattern generator so the fb-writer stage can consume it as is.
module gfx_line
  import gfx_line_pkg::*;
#(
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int PIXEL_BITS = 12,
  localparam int FB_X_BITS = fb_bits(FB_WIDTH),
  localparam int FB_Y_BITS = fb_bits(FB_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [FB_X_BITS-1:0]  cmd_x0,
  input  logic [FB_Y_BITS-1:0]  cmd_y0,
  input  logic [FB_X_BITS-1:0]  cmd_x1,
  input  logic [FB_Y_BITS-1:0]  cmd_y1,
  input  logic [PIXEL_BITS-1:0] cmd_color,
  input  logic                  inc,
  output logic [FB_X_BITS-1:0]  x,
  output logic [FB_Y_BITS-1:0]  y,
  output logic [PIXEL_BITS-1:0] color,
  output logic                  valid,
  output logic                  last,
  output logic                  busy
);

  // Two guard bits: one for the sign, one so that 2*err never overflows.
  localparam int W = max2(FB_X_BITS, FB_Y_BITS) + 2;

  logic [1:0]            state;
  logic [FB_X_BITS-1:0]  x1_q;
  logic [FB_Y_BITS-1:0]  y1_q;
  logic signed [W-1:0]   dx_q;
  logic signed [W-1:0]   dy_q;
  logic signed [W-1:0]   err_q;
  logic                  sx_neg;
  logic                  sy_neg;

  logic signed [W-1:0]   x0_s, x1_s, y0_s, y1_s;
  logic signed [W-1:0]   dx_c, dy_c;
  logic signed [W-1:0]   err_step;
  logic                  step_x, step_y;

  // One Bresenham step: returns {step_x, step_y, next err}. Both tests use the
  // err value from before the step, which is what allows a diagonal move.
  function automatic logic [W+1:0] bres_step(input logic signed [W-1:0] err,
                                             input logic signed [W-1:0] dx,
                                             input logic signed [W-1:0] dy);
    logic signed [W-1:0] e2;
    logic signed [W-1:0] err_n;
    logic                stx;
    logic                sty;
    e2    = err <<< 1;
    err_n = err;
    stx   = 1'b0;
    sty   = 1'b0;
    if (e2 >= dy) begin
      err_n = err_n + dy;
      stx   = 1'b1;
    end
    if (e2 <= dx) begin
      err_n = err_n + dx;
      sty   = 1'b1;
    end
    return {stx, sty, err_n};
  endfunction

  assign busy      = (state != ST_IDLE);
  assign cmd_ready = !busy;
  assign valid     = (state == ST_DRAW);
  assign last      = valid && (x == x1_q) && (y == y1_q);

  // Setup arithmetic: x/y already hold the start point during SETUP.
  always_comb begin
    x0_s = $signed({{(W-FB_X_BITS){1'b0}}, x});
    x1_s = $signed({{(W-FB_X_BITS){1'b0}}, x1_q});
    y0_s = $signed({{(W-FB_Y_BITS){1'b0}}, y});
    y1_s = $signed({{(W-FB_Y_BITS){1'b0}}, y1_q});
    dx_c = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
    dy_c = (y1_s >= y0_s) ? (y0_s - y1_s) : (y1_s - y0_s);
    {step_x, step_y, err_step} = bres_step(err_q, dx_q, dy_q);
  end

  // Command FSM and pixel walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      x      <= '0;
      y      <= '0;
      color  <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      err_q  <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Start point goes straight into the walking position registers.
            x     <= cmd_x0;
            y     <= cmd_y0;
            x1_q  <= cmd_x1;
            y1_q  <= cmd_y1;
            color <= cmd_color;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          dx_q   <= dx_c;
          dy_q   <= dy_c;
          err_q  <= dx_c + dy_c;
          sx_neg <= !(x < x1_q);
          sy_neg <= !(y < y1_q);
          state  <= ST_DRAW;
        end
        ST_DRAW: begin
          if (inc) begin
            if (last) begin
              state <= ST_IDLE;
            end else begin
              err_q <= err_step;
              if (step_x) x <= sx_neg ? (x - 1'b1) : (x + 1'b1);
              if (step_y) y <= sy_neg ? (y - 1'b1) : (y + 1'b1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
